// File: rtl/timer_sched_pkg.sv
// timer_sched_pkg: shared constants and the controller state type for the
// interval-timer controller (timer_sched) and its count datapath.
package timer_sched_pkg;

    // Default width of the period and count datapath.
    localparam int TIMER_N = 8;

    // Controller states, fixed 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/timer_datapath.sv
// timer_datapath: N-bit count register with synchronous clear and
// increment enable. Clear has priority over increment; wraps modulo 2^N.
module timer_datapath
    import timer_sched_pkg::*;
#(
    parameter int N = TIMER_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [N-1:0] q
);

    logic [N-1:0] q_q;
    logic [N-1:0] q_d;

    // Next count: clear beats increment, otherwise hold.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = q_q + N'(1);
        end
    end

    // Count register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/timer_sched.sv
// timer_sched: interval-timer controller. Sequences the count datapath
// through IDLE/RUN/DONE, latches period and mode at start, and emits
// single-cycle tick/done pulses.
// Optional feature: define TIMER_PRESCALE_EN to add a prescaler so the count
// advances once every PRESCALE clocks; otherwise it advances every clock.
module timer_sched
    import timer_sched_pkg::*;
#(
    parameter int N = TIMER_N
`ifdef TIMER_PRESCALE_EN
    ,
    parameter int PRESCALE = 4
`endif
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         stop,
    input  logic         periodic,
    input  logic [N-1:0] period,
    output logic         busy,
    output logic         tick,
    output logic         done,
    output logic [N-1:0] count
);

    state_e       state_q, state_d;
    logic [N-1:0] period_q, period_d;
    logic         periodic_q, periodic_d;
    logic         dp_en;
    logic         dp_clr;
    logic         step;
    logic         terminal;

`ifdef TIMER_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] psc_q, psc_d;

    assign step = (psc_q == PW'(PRESCALE - 1));

    // Prescaler runs only in RUN; held at zero elsewhere and cleared on stop.
    always_comb begin
        psc_d = '0;
        if (state_q == ST_RUN && !stop) begin
            psc_d = step ? '0 : psc_q + PW'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (rst) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_d;
        end
    end
`else
    assign step = 1'b1;
`endif

    // Last step of an interval; period 0 wraps to 2^N-1 and so means 2^N steps.
    assign terminal = (state_q == ST_RUN) && step && (count == period_q - N'(1));

    // State, latched period and latched mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            period_q   <= '0;
            periodic_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            period_q   <= period_d;
            periodic_q <= periodic_d;
        end
    end

    // Next-state and datapath control; stop outranks the terminal step.
    always_comb begin
        state_d    = state_q;
        period_d   = period_q;
        periodic_d = periodic_q;
        dp_en      = 1'b0;
        dp_clr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d    = ST_RUN;
                    period_d   = period;
                    periodic_d = periodic;
                    dp_clr     = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    dp_clr  = 1'b1;
                end else if (terminal) begin
                    if (periodic_q) begin
                        dp_clr = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    dp_en = step;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                dp_clr  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                dp_clr  = 1'b1;
            end
        endcase
    end

    assign tick = terminal;
    assign done = (state_q == ST_DONE);
    assign busy = (state_q == ST_RUN) || (state_q == ST_DONE);

    timer_datapath #(.N(N)) u_datapath (
        .clk (clk),
        .rst (rst),
        .en  (dp_en),
        .clr (dp_clr),
        .q   (count)
    );

endmodule

// File: tb/tb_timer_sched.sv
// tb_timer_sched: directed plus randomized bench for timer_sched, checked
// cycle by cycle against an interval-position reference model.
module tb_timer_sched;

`ifdef TIMER_PRESCALE_EN
    localparam int PSC = 4;
`else
    localparam int PSC = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       periodic;
    logic [7:0] period;
    logic       busy;
    logic       tick;
    logic       done;
    logic [7:0] count;

    always #5 clk = ~clk;

    timer_sched dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .periodic (periodic),
        .period   (period),
        .busy     (busy),
        .tick     (tick),
        .done     (done),
        .count    (count)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: position inside the current interval, in steps.
    bit m_run;
    bit m_done;
    bit m_per;
    int m_pos;
    int m_len;
    int m_clk;

    // Observed values from the most recent cycle and running pulse tallies.
    logic       last_busy, last_tick, last_done;
    logic [7:0] last_count;
    int         tick_seen, done_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_done = 1'b0;
        m_per  = 1'b0;
        m_pos  = 0;
        m_len  = 256;
        m_clk  = 0;
    endtask

    // One clock: drive inputs, check outputs against the model, advance model.
    task automatic cycle(input bit r, input bit s, input bit sp, input bit pm, input logic [7:0] pr);
        bit strobe;
        bit e_tick;
        @(negedge clk);
        rst = r; start = s; stop = sp; periodic = pm; period = pr;
        strobe = (m_clk % PSC) == (PSC - 1);
        e_tick = m_run && strobe && (m_pos == m_len - 1);
        check("busy",  {31'd0, busy},  {31'd0, (m_run || m_done)});
        check("tick",  {31'd0, tick},  {31'd0, e_tick});
        check("done",  {31'd0, done},  {31'd0, m_done});
        check("count", {24'd0, count}, m_pos);
        last_busy = busy; last_tick = tick; last_done = done; last_count = count;
        if (tick === 1'b1) tick_seen++;
        if (done === 1'b1) done_seen++;
        if (r) begin
            model_reset();
        end else if (m_run) begin
            if (sp) begin
                m_run = 1'b0;
                m_pos = 0;
            end else if (e_tick) begin
                if (m_per) m_pos = 0;
                else begin
                    m_run  = 1'b0;
                    m_done = 1'b1;
                end
            end else if (strobe) begin
                m_pos++;
            end
            m_clk++;
        end else if (m_done) begin
            m_done = 1'b0;
            m_pos  = 0;
        end else if (s && !sp) begin
            m_run = 1'b1;
            m_per = pm;
            m_len = (pr == 8'd0) ? 256 : int'(pr);
            m_pos = 0;
            m_clk = 0;
        end
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'(($urandom)));
    endtask

    initial begin
        int n;
        int first_tick;
        int done_at;
        bit r, s, sp;

        rst = 1'b1; start = 1'b0; stop = 1'b0; periodic = 1'b0; period = 8'd0;
        repeat (2) @(posedge clk);
        model_reset();
        tick_seen = 0; done_seen = 0;

        // Reset state and a quiet idle cycle.
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'd7);
        idle_cycle();
        check("reset_busy",  {31'd0, last_busy},  32'd0);
        check("reset_count", {24'd0, last_count}, 32'd0);

        // One-shot, period 5: tick on step 5, done one cycle later.
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'd5);
        n = 0; first_tick = -1; done_at = -1; tick_seen = 0; done_seen = 0;
        while (done_seen == 0 && n < 20 * PSC) begin
            idle_cycle();
            n++;
            if (last_tick === 1'b1 && first_tick < 0) first_tick = n;
            if (last_done === 1'b1) done_at = n;
        end
        check("os5_first_tick", first_tick, 5 * PSC);
        check("os5_done_at",    done_at,    5 * PSC + 1);
        idle_cycle();
        check("os5_idle_busy",  {31'd0, last_busy},  32'd0);
        check("os5_idle_count", {24'd0, last_count}, 32'd0);

        // Periodic, period 3, over 12 steps: four ticks, no done, always busy.
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'd3);
        tick_seen = 0; done_seen = 0;
        for (int i = 0; i < 12 * PSC; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'(($urandom)));
            check("per3_busy", {31'd0, last_busy}, 32'd1);
        end
        check("per3_ticks", tick_seen, 4);
        check("per3_dones", done_seen, 0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        idle_cycle();

        // One-shot, period 0: the full 2^8-step interval.
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        n = 0; first_tick = -1;
        while (first_tick < 0 && n < 300 * PSC) begin
            idle_cycle();
            n++;
            if (last_tick === 1'b1) first_tick = n;
        end
        check("p0_first_tick", first_tick, 256 * PSC);
        repeat (3) idle_cycle();

        // Stop at count 2 with period 5: back to idle, no tick, no done.
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'd5);
        n = 0;
        idle_cycle();
        while (last_count !== 8'd2 && n < 20 * PSC) begin
            idle_cycle();
            n++;
        end
        check("stop_reached_2", {24'd0, last_count}, 32'd2);
        tick_seen = 0; done_seen = 0;
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'd5);
        repeat (8) idle_cycle();
        check("stop_ticks", tick_seen, 0);
        check("stop_dones", done_seen, 0);

        // start and stop together in idle: stop wins.
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'd4);
        idle_cycle();
        check("ss_busy", {31'd0, last_busy}, 32'd0);

        // Reset mid-run clears everything.
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'd10);
        repeat (4) idle_cycle();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        idle_cycle();
        check("rst_run_busy",  {31'd0, last_busy},  32'd0);
        check("rst_run_tick",  {31'd0, last_tick},  32'd0);
        check("rst_run_count", {24'd0, last_count}, 32'd0);

        // Randomized traffic: mostly short periods, occasional stop and reset.
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 99) == 0);
            s  = ($urandom_range(0, 3) == 0);
            sp = ($urandom_range(0, 24) == 0);
            cycle(r, s, sp, 1'($urandom),
                  ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
